seq_match_monitor: RTL and testbench
====================================

# seq_match_monitor

Synthesizable RTL monitor that runs downstream of the property-checked signal groups. It consumes one group's a/b/c/d signals each clock and detects the antecedent a ##1 b[*B_REPS] ##1 c[*C_REPS]. It checks the overlapped consequent d in the cycle that completes the antecedent, and reports pass/fail events, saturating counters and a sticky first-failure record. It is the silicon-observable counterpart of the group assertions, used where simulation assertions are unavailable (emulation, FPGA, post-silicon debug).

## Interface
- B_REPS, 2, consecutive b cycles required after a (≥1)
- C_REPS, 3, consecutive c cycles required after the b run (≥1)
- CNT_W, 16, width of pass/fail counters
- TS_W, 32, width of the free-running cycle timestamp
- clk  input  1  sole clock, all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- en_i  input  1  allows new attempts to start
- clear_i  input  1  synchronous clear of counters and sticky error state
- a_i, b_i, c_i, d_i  input  1 each  monitored group signals, sampled at posedge clk
- pass_o  output  1  one-cycle pulse: antecedent matched with d_i=1
- fail_o  output  1  one-cycle pulse: antecedent matched with d_i=0
- pass_cnt_o  output  CNT_W  saturating pass count
- fail_cnt_o  output  CNT_W  saturating fail count
- err_sticky_o  output  1  set on first failure, held until clear_i or reset
- first_fail_ts_o  output  TS_W  timestamp of the first failure since clear/reset

## Operation
- Antecedent length L = 1 + B_REPS + C_REPS; element k: k=0 → a_i, 1..B_REPS → b_i, remaining → c_i.
- Thread tracking: stage register s[0..L-2]; s[k] set means some attempt has matched elements 0..k. Each edge: s[0] <= en_i & a_i; s[k] <= s[k-1] & elem_k.
- A new attempt may start every cycle; overlapping attempts are tracked independently. Attempts merged into the same stage bit complete together and are reported as one event.
- match (combinational) = s[L-2] & c_i. This is the cycle the last c is sampled.
- Consequent is overlapped: on match, d_i in the same cycle decides pass or fail.
- en_i=0 blocks only new starts; in-flight attempts run to completion.
- Non-matching attempts vanish silently; no vacuous pass is counted.
- Counters increment by 1 per event and saturate at 2^CNT_W-1, with no wrap.
- Timestamp counter: TS_W bits, free-running from 0 after reset, wraps modulo 2^TS_W.
- first_fail_ts_o captures the timestamp of the match cycle when a fail occurs with err_sticky_o=0. Later failures do not update it.
- clear_i=1: pass_cnt_o, fail_cnt_o and err_sticky_o go to 0 next edge; first_fail_ts_o goes to 0. Stage registers and the timestamp counter are unaffected.
- clear_i together with a match: clear wins. The event is not counted and does not set sticky, but pass_o/fail_o still pulse.

## Timing
- Reset (rst_n=0, asynchronous): all s[k]=0; pass_o, fail_o, err_sticky_o = 0; both counters 0; first_fail_ts_o 0; timestamp 0.
- Latency: pass_o/fail_o are registered and assert for exactly one cycle, the edge after the match cycle.
- Counters and err_sticky_o update on the same edge as the pulse.
- Minimum spacing between events: 1 cycle. Back-to-back overlapping matches give consecutive pulses.
- Reset mid-attempt: all threads are lost. No event fires for an antecedent spanning the reset release.
- Timestamp wrap: first_fail_ts_o records the wrapped value, with no special handling.

## Test plan
- Defaults, en_i=1: a@0, b@1-2, c@3-5, d=1@5 → pass_o=1 in cycle 6 only; pass_cnt_o=1; fail_cnt_o=0.
- Same sequence with d=0@5 → fail_o@6; fail_cnt_o=1; err_sticky_o=1; first_fail_ts_o=5. A second fail later leaves first_fail_ts_o=5.
- Overlap: a@0-1, b@1-3, c@3-6, d=1@5-6 → pass_o@6 and @7; pass_cnt_o=2.
- Broken run: a@0, b@1-2, c@3-4, c=0@5 → no pulses, counters unchanged. Repeat with en_i=0@0 → no event.
- Saturation with CNT_W=4: 17 passing antecedents → pass_cnt_o stops at 15. clear_i coincident with a match → pulse seen, counter 0 next cycle.
- rst_n low at cycle 3 of a valid sequence, released at 4 → all outputs 0, no pulse for that sequence. A fresh sequence afterwards passes normally.

Source files
------------

// File: rtl/seq_match_monitor.sv
// Hardware monitor for a ##1 b[*B_REPS] ##1 c[*C_REPS] |-> d (overlapped consequent).
// Reports pass/fail pulses, saturating counters and a sticky first-failure timestamp.
module seq_match_monitor #(
    parameter int B_REPS = 2,
    parameter int C_REPS = 3,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             c_i,
    input  logic             d_i,
    output logic             pass_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             err_sticky_o,
    output logic [TS_W-1:0]  first_fail_ts_o
);
    localparam int L  = 1 + B_REPS + C_REPS;
    localparam int NS = L - 1;

    logic [NS-1:0] stg;
    logic [NS-1:0] elem;
    logic [TS_W-1:0] ts;
    logic match;

    // elem[k] is the condition that advances a thread into stage k
    for (genvar k = 0; k < NS; k++) begin : g_elem
        if (k == 0) begin : g_a
            assign elem[k] = en_i & a_i;
        end else if (k <= B_REPS) begin : g_b
            assign elem[k] = b_i;
        end else begin : g_c
            assign elem[k] = c_i;
        end
    end

    assign match = stg[NS-1] & c_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg             <= '0;
            ts              <= '0;
            pass_o          <= 1'b0;
            fail_o          <= 1'b0;
            pass_cnt_o      <= '0;
            fail_cnt_o      <= '0;
            err_sticky_o    <= 1'b0;
            first_fail_ts_o <= '0;
        end else begin
            stg    <= {stg[NS-2:0], 1'b1} & elem;
            ts     <= ts + TS_W'(1);
            pass_o <= match & d_i;
            fail_o <= match & ~d_i;
            // clear takes priority over a coincident event; the pulse still fires
            if (clear_i) begin
                pass_cnt_o      <= '0;
                fail_cnt_o      <= '0;
                err_sticky_o    <= 1'b0;
                first_fail_ts_o <= '0;
            end else if (match) begin
                if (d_i) begin
                    if (pass_cnt_o != '1) pass_cnt_o <= pass_cnt_o + CNT_W'(1);
                end else begin
                    if (fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + CNT_W'(1);
                    if (!err_sticky_o) begin
                        err_sticky_o    <= 1'b1;
                        first_fail_ts_o <= ts;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_match_monitor.sv
// Directed bench: expected pulses are queued at stimulus time and matched against DUT pulses.
module tb_seq_match_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_i = 1'b1, clear_i = 1'b0, a_i = 1'b0, b_i = 1'b0, c_i = 1'b0, d_i = 1'b0;

    logic        pass_o, fail_o, err_sticky_o;
    logic [15:0] pass_cnt_o, fail_cnt_o;
    logic [31:0] first_fail_ts_o;
    logic        s_pass_o, s_fail_o, s_err_sticky_o;
    logic [3:0]  s_pass_cnt_o, s_fail_cnt_o;
    logic [31:0] s_first_fail_ts_o;

    seq_match_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .clear_i(clear_i),
        .a_i(a_i), .b_i(b_i), .c_i(c_i), .d_i(d_i),
        .pass_o(pass_o), .fail_o(fail_o), .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
        .err_sticky_o(err_sticky_o), .first_fail_ts_o(first_fail_ts_o)
    );

    seq_match_monitor #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .clear_i(clear_i),
        .a_i(a_i), .b_i(b_i), .c_i(c_i), .d_i(d_i),
        .pass_o(s_pass_o), .fail_o(s_fail_o), .pass_cnt_o(s_pass_cnt_o), .fail_cnt_o(s_fail_cnt_o),
        .err_sticky_o(s_err_sticky_o), .first_fail_ts_o(s_first_fail_ts_o)
    );

    always #5 clk = ~clk;

    // cycle index as sampled by each edge since reset release
    int unsigned tsm;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tsm <= 0;
        else        tsm <= tsm + 1;
    end

    typedef struct { int unsigned when; bit pass; } ev_t;
    ev_t q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned exp_pass = 0, exp_fail = 0, exp_sat = 0, exp_fts = 0;
    bit exp_sticky = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (q.size() > 0 && q[0].when < tsm) begin
                ev_t m;
                m = q.pop_front();
                chk("pulse_missing", 64'(tsm), 64'(m.when));
            end
            if (pass_o | fail_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, pass_o, fail_o}, 64'd0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("pulse_cycle", 64'(tsm), 64'(e.when));
                    chk("pulse_kind", {62'd0, pass_o, fail_o}, e.pass ? 64'd2 : 64'd1);
                end
            end
        end
    end

    task automatic ev(input int unsigned mts, input bit p, input bit clr);
        q.push_back('{when: mts + 1, pass: p});
        if (!clr) begin
            if (p) begin
                exp_pass++;
                if (exp_sat < 15) exp_sat++;
            end else begin
                exp_fail++;
                if (!exp_sticky) begin
                    exp_sticky = 1'b1;
                    exp_fts    = mts;
                end
            end
        end
    endtask

    task automatic drive_idle();
        a_i = 0; b_i = 0; c_i = 0; d_i = 0; en_i = 1; clear_i = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_idle();
        end
    endtask

    // bit i of each mask is the value driven in cycle i; k1/k2 are expected match cycles
    task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input int n, input logic [7:0] en,
                           input logic [7:0] clr, input int k1, input bit p1,
                           input int k2, input bit p2);
        int unsigned st;
        st = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) st = tsm;
            a_i = a[i]; b_i = b[i]; c_i = c[i]; d_i = d[i];
            en_i = en[i]; clear_i = clr[i];
            if (clr[i]) begin
                exp_pass = 0; exp_fail = 0; exp_sat = 0; exp_sticky = 0; exp_fts = 0;
            end
            if (i == k1) ev(st + i, p1, clr[i]);
            if (i == k2) ev(st + i, p2, clr[i]);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic check_state(input string tag);
        idle(3);
        chk({tag, "_pass_cnt"}, 64'(pass_cnt_o), 64'(exp_pass));
        chk({tag, "_fail_cnt"}, 64'(fail_cnt_o), 64'(exp_fail));
        chk({tag, "_sticky"}, 64'(err_sticky_o), 64'(exp_sticky));
        chk({tag, "_first_ts"}, 64'(first_fail_ts_o), 64'(exp_fts));
        chk({tag, "_sat_cnt"}, 64'(s_pass_cnt_o), 64'(exp_sat));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pass_o"}, 64'(pass_o), 64'd0);
        chk({tag, "_fail_o"}, 64'(fail_o), 64'd0);
        chk({tag, "_pass_cnt"}, 64'(pass_cnt_o), 64'd0);
        chk({tag, "_fail_cnt"}, 64'(fail_cnt_o), 64'd0);
        chk({tag, "_sticky"}, 64'(err_sticky_o), 64'd0);
        chk({tag, "_first_ts"}, 64'(first_fail_ts_o), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // single pass, then fails with a held first-failure timestamp
        run_seq(8'b000001, 8'b000110, 8'b111000, 8'b100000, 6, 8'hFF, 8'h00, 5, 1, -1, 0);
        check_state("pass1");
        run_seq(8'b000001, 8'b000110, 8'b111000, 8'b000000, 6, 8'hFF, 8'h00, 5, 0, -1, 0);
        check_state("fail1");
        run_seq(8'b000001, 8'b000110, 8'b111000, 8'b000000, 6, 8'hFF, 8'h00, 5, 0, -1, 0);
        check_state("fail2");

        // overlapping attempts complete on consecutive cycles
        run_seq(8'b0000011, 8'b0001110, 8'b1111000, 8'b1100000, 7, 8'hFF, 8'h00, 5, 1, 6, 1);
        check_state("overlap");

        // broken c run, blocked start, and en dropped after the start
        run_seq(8'b000001, 8'b000110, 8'b011000, 8'b100000, 6, 8'hFF, 8'h00, -1, 0, -1, 0);
        check_state("broken");
        run_seq(8'b000001, 8'b000110, 8'b111000, 8'b100000, 6, 8'hFE, 8'h00, -1, 0, -1, 0);
        check_state("en_block");
        run_seq(8'b000001, 8'b000110, 8'b111000, 8'b100000, 6, 8'h01, 8'h00, 5, 1, -1, 0);
        check_state("en_inflight");

        // clear, then saturation on the 4-bit instance
        run_seq(8'b0, 8'b0, 8'b0, 8'b0, 1, 8'hFF, 8'h01, -1, 0, -1, 0);
        check_state("clear");
        repeat (17)
            run_seq(8'b000001, 8'b000110, 8'b111000, 8'b100000, 6, 8'hFF, 8'h00, 5, 1, -1, 0);
        check_state("sat");

        // clear coincident with a pass and with a fail
        run_seq(8'b000001, 8'b000110, 8'b111000, 8'b100000, 6, 8'hFF, 8'b100000, 5, 1, -1, 0);
        check_state("clr_pass");
        run_seq(8'b000001, 8'b000110, 8'b111000, 8'b000000, 6, 8'hFF, 8'b100000, 5, 0, -1, 0);
        check_state("clr_fail");
        run_seq(8'b000001, 8'b000110, 8'b111000, 8'b000000, 6, 8'hFF, 8'h00, 5, 0, -1, 0);
        check_state("fail_after_clr");

        // reset in the middle of an attempt
        run_seq(8'b001, 8'b110, 8'b000, 8'b000, 3, 8'hFF, 8'h00, -1, 0, -1, 0);
        @(negedge clk);
        rst_n = 1'b0; b_i = 1; c_i = 1;
        #1;
        check_zero("mid_reset");
        exp_pass = 0; exp_fail = 0; exp_sat = 0; exp_sticky = 0; exp_fts = 0;
        @(negedge clk);
        rst_n = 1'b1; b_i = 0; c_i = 1;
        @(negedge clk);
        c_i = 1; d_i = 1;
        @(negedge clk);
        drive_idle();
        check_state("post_reset");
        run_seq(8'b000001, 8'b000110, 8'b111000, 8'b100000, 6, 8'hFF, 8'h00, 5, 1, -1, 0);
        check_state("fresh");

        idle(2);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
